datapath_trace_capture: RTL
===========================

// Module: datapath_trace_capture
//
// PURPOSE
//   Consumer side of the DataPath observation outputs (WriteData, ProgramCount,
//   HIRegOutput, LORegOutput). Captures one 128-bit trace record per new
//   ProgramCount value into an on-chip FIFO. A host, debug UART or bench
//   drains the FIFO through a show-ahead read port. Sits beside DataPath in the
//   top level and never back-pressures the processor.
//
// PARAMETERS
//   DEPTH   16  FIFO entries; power of two, >= 2
//   ADDR_W  4   log2(DEPTH)
//
// PORTS
//   Clk            in   1       system clock, rising edge
//   Reset          in   1       asynchronous, active-low reset (0 = reset)
//   Enable         in   1       capture enable
//   WriteData      in   32      DataPath write-back data
//   ProgramCount   in   32      DataPath PC
//   HIRegOutput    in   32      DataPath HI register
//   LORegOutput    in   32      DataPath LO register
//   RdReq          in   1       pop head record; honoured only when RdValid=1
//   ClearOverflow  in   1       clears Overflow and DropCount
//   RdValid        out  1       FIFO non-empty; head record on Rd* is valid
//   RdPC           out  32      head record PC
//   RdData         out  32      head record WriteData
//   RdHI           out  32      head record HI
//   RdLO           out  32      head record LO
//   Count          out  ADDR_W+1  occupancy, 0..DEPTH
//   Overflow       out  1       sticky: a record was dropped because FIFO full
//   DropCount      out  8       dropped-record count, saturates at 8'hFF
//
// BEHAVIOUR
//   - Reset low (async): FSM=IDLE, pointers/Count=0, RdValid=0, Rd*=0,
//     Overflow=0, DropCount=0, last_pc=0. FIFO contents discarded.
//   - FSM, sampled at each rising Clk:
//       IDLE : Enable=0. No capture. Enable=1 -> PRIME.
//       PRIME: capture record unconditionally; last_pc<=ProgramCount; -> RUN
//              (-> IDLE if Enable=0 this cycle, and no capture).
//       RUN  : capture iff ProgramCount != last_pc, then last_pc<=ProgramCount.
//              Enable=0 -> IDLE (no capture that cycle).
//   - Disabling keeps FIFO contents and read port live; re-enabling goes via
//     PRIME, so the current PC is always recorded once.
//   - Record = {ProgramCount, WriteData, HIRegOutput, LORegOutput} as present
//     at the capturing edge. Latency: captured at edge N -> RdValid=1 and
//     visible on Rd* after edge N (if FIFO was empty).
//   - Read: show-ahead. Rd* = head entry when RdValid=1, else 32'h0.
//     RdReq=1 and RdValid=1 at edge -> head advances. RdReq with RdValid=0 is
//     ignored (no underflow, Count stays 0).
//   - Push and pop same edge: both take effect, Count unchanged; legal when
//     full (pop frees slot, push accepted, no drop).
//   - Push when full without pop: record dropped, contents untouched,
//     Overflow<=1, DropCount<=DropCount+1 (saturating at 255).
//   - ClearOverflow=1: Overflow<=0, DropCount<=0; if a drop occurs the same
//     edge, the drop wins (Overflow=1, DropCount=1).
//   - Pointers ADDR_W bits, wrap modulo DEPTH; Count is authoritative for
//     full (Count==DEPTH) and empty (Count==0).
//   - Reset asserted mid-capture or mid-read returns everything to reset values
//     immediately, independent of Clk.
//
// TESTING
//   1 Reset low, Enable=1, PC=0x0 held -> one record only (PRIME), RdPC=0x0,
//     Count=1; PC held 10 cycles more -> Count stays 1.
//   2 PC steps 0x0,0x4,0x8 with WriteData 0x11,0x22,0x33 -> 3 records; pops
//     return RdPC/RdData (0x0,0x11),(0x4,0x22),(0x8,0x33) in order, then RdValid=0.
//   3 DEPTH+3 distinct PCs, no reads -> Count=16, Overflow=1, DropCount=3;
//     first 16 records intact; ClearOverflow -> Overflow=0, DropCount=0.
//   4 FIFO full, new PC with RdReq=1 same edge -> Count stays 16, Overflow=0,
//     new record is last out; wrap across pointer boundary read back correctly.
//   5 RdReq pulsed while empty -> Count=0, RdValid=0, Rd*=0; Enable dropped
//     mid-stream -> no captures, existing records still drain; re-enable
//     captures current PC once.
//   6 Reset pulsed low between clock edges with Count=5 -> Count=0, RdValid=0,
//     Overflow=0 immediately, before the next Clk edge.

Source files
------------

// File: rtl/datapath_trace_capture.sv
// Trace capture for DataPath observation outputs: one 128-bit record per new
// ProgramCount value, buffered in a show-ahead FIFO that never stalls the core.
module datapath_trace_capture #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [31:0]       WriteData,
  input  logic [31:0]       ProgramCount,
  input  logic [31:0]       HIRegOutput,
  input  logic [31:0]       LORegOutput,
  input  logic              RdReq,
  input  logic              ClearOverflow,
  output logic              RdValid,
  output logic [31:0]       RdPC,
  output logic [31:0]       RdData,
  output logic [31:0]       RdHI,
  output logic [31:0]       RdLO,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic [7:0]        DropCount
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_last_pc;
  logic [127:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_accept;
  logic                w_drop;
  logic [127:0]        w_head;

  // Capture FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and capture decision; disabling always bypasses capture
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_next = Enable ? ST_PRIME : ST_IDLE;
      ST_PRIME: begin
        w_next = Enable ? ST_RUN : ST_IDLE;
        w_push = Enable;
      end
      ST_RUN: begin
        w_next = Enable ? ST_RUN : ST_IDLE;
        w_push = Enable && (ProgramCount != r_last_pc);
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_full   = (r_count == LP_FULL);
  assign w_pop    = RdReq && (r_count != '0);
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Last PC tracker; updated on every capture attempt, including drops
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      r_last_pc <= '0;
    else if (w_push) r_last_pc <= ProgramCount;
  end

  // Record storage; contents are meaningless while Count is zero
  always_ff @(posedge Clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= {ProgramCount, WriteData, HIRegOutput, LORegOutput};
  end

  // Pointers and occupancy
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a same-edge drop beats clear
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (ClearOverflow)            r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ClearOverflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign RdValid   = (r_count != '0);
  assign RdPC      = RdValid ? w_head[127:96] : '0;
  assign RdData    = RdValid ? w_head[95:64]  : '0;
  assign RdHI      = RdValid ? w_head[63:32]  : '0;
  assign RdLO      = RdValid ? w_head[31:0]   : '0;
  assign Count     = r_count;
  assign Overflow  = r_overflow;
  assign DropCount = r_drop_cnt;

endmodule
